// File: rtl/stream_cipher_pkg.sv
// Shared types and helpers for the stream XOR cipher combiner.
package stream_cipher_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FLUSH   = 3'd1,
    WAIT    = 3'd2,
    DISCARD = 3'd3,
    RUN     = 3'd4
  } state_t;

  // FIFO pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_xor_cipher_if.sv
// Keystream, input and output streams of the cipher combiner.
// Handshake rule for all three streams: a word transfers on a rising clk edge
// where valid and ready are both 1; valid never waits on ready, and a producer
// holding valid=1 keeps its data stable until that transfer happens.
interface stream_xor_cipher_if #(
  parameter int W = stream_cipher_pkg::W_DEFAULT
);
  logic         ks_valid;
  logic [W-1:0] ks_data;
  logic         ks_ready;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;

  // Source/sink side (keystream generator, text source and sink)
  modport master (
    output ks_valid, ks_data, in_valid, in_data, out_ready,
    input  ks_ready, in_ready, out_valid, out_data
  );

  // Cipher block side
  modport slave (
    input  ks_valid, ks_data, in_valid, in_data, out_ready,
    output ks_ready, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ks_fifo.sv
// Keystream buffer: synchronous FIFO with a synchronous clear.
// Pointers wrap modulo 2*DEPTH; the MSB distinguishes full from empty.
module ks_fifo
  import stream_cipher_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [W-1:0]  mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer update; clear drops all buffered words
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage write; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/stream_xor_cipher.sv
// Stream-cipher combiner: buffers keystream words, drops the first DROP_N
// of each session, then XORs each data word with the next keystream word.
// Optional statistics outputs under STREAM_XOR_CIPHER_STATS_EN.
module stream_xor_cipher
  import stream_cipher_pkg::*;
#(
  parameter int W      = W_DEFAULT,
  parameter int DEPTH  = 4,
  parameter int DROP_N = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      ks_init_done,
  stream_xor_cipher_if.slave        bus,
  output logic                      busy,
`ifdef STREAM_XOR_CIPHER_STATS_EN
  output logic [31:0]               word_count,
  output logic [7:0]                ks_dropped,
`endif
  output state_t                    state
);
  state_t       state_q;
  state_t       state_d;
  logic [7:0]   drop_cnt;
  logic         fifo_full;
  logic         fifo_empty;
  logic [W-1:0] fifo_head;
  logic         ks_hs;
  logic         in_hs;
  logic         out_hs;

  assign bus.ks_ready = (state_q == DISCARD) || ((state_q == RUN) && !fifo_full);
  assign bus.in_ready = (state_q == RUN) && !fifo_empty && (!bus.out_valid || bus.out_ready);
  assign ks_hs  = bus.ks_valid && bus.ks_ready;
  assign in_hs  = bus.in_valid && bus.in_ready;
  assign out_hs = bus.out_valid && bus.out_ready;
  assign busy   = (state_q != IDLE);
  assign state  = state_q;

  ks_fifo #(.W(W), .DEPTH(DEPTH)) u_ks_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (state_q == FLUSH),
    .push      (ks_hs && (state_q == RUN)),
    .push_data (bus.ks_data),
    .pop       (in_hs),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: start restarts the session from any state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      FLUSH:   state_d = WAIT;
      WAIT:    if (ks_init_done) state_d = (DROP_N > 0) ? DISCARD : RUN;
      DISCARD: if (ks_hs && (drop_cnt == 8'd1)) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (start) state_d = FLUSH;
  end

  // Discard counter: loaded per session, counts down on dropped words
  always_ff @(posedge clk) begin
    if (rst)                               drop_cnt <= 8'd0;
    else if (state_q == FLUSH)             drop_cnt <= 8'(DROP_N);
    else if (state_q == DISCARD && ks_hs)  drop_cnt <= drop_cnt - 8'd1;
  end

  // Output register: a pending word survives a restart until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else if (in_hs) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= bus.in_data ^ fifo_head;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef STREAM_XOR_CIPHER_STATS_EN
  // Session statistics; word_count saturates instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || state_q == FLUSH) begin
      word_count <= 32'd0;
      ks_dropped <= 8'd0;
    end else begin
      if (out_hs && (word_count != 32'hFFFF_FFFF)) word_count <= word_count + 32'd1;
      if (state_q == DISCARD && ks_hs)             ks_dropped <= ks_dropped + 8'd1;
    end
  end
`else
  logic unused_out_hs;
  assign unused_out_hs = out_hs;
`endif

endmodule

// File: tb/tb_stream_xor_cipher.sv
// Bench for stream_xor_cipher: u_a (DROP_N=0) is the main device, u_b is
// chained behind u_a for the encrypt/decrypt round trip, u_d has DROP_N=2.
module tb_stream_xor_cipher;
  import stream_cipher_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic start;
  logic ks_init_done;
  logic chain;
  logic a_out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  logic [7:0] exp_q[$];
  logic [7:0] ks_arr[64];
  logic [7:0] pt_arr[64];

  stream_xor_cipher_if #(.W(8)) if_a ();
  stream_xor_cipher_if #(.W(8)) if_b ();
  stream_xor_cipher_if #(.W(8)) if_d ();

  logic busy_a, busy_b, busy_d;
  state_t st_a, st_b, st_d;
`ifdef STREAM_XOR_CIPHER_STATS_EN
  logic [31:0] wc_a, wc_b, wc_d;
  logic [7:0]  kd_a, kd_b, kd_d;
`endif

  stream_xor_cipher #(.W(8), .DEPTH(4), .DROP_N(0)) u_a (
    .clk(clk), .rst(rst), .start(start), .ks_init_done(ks_init_done),
    .bus(if_a.slave), .busy(busy_a),
`ifdef STREAM_XOR_CIPHER_STATS_EN
    .word_count(wc_a), .ks_dropped(kd_a),
`endif
    .state(st_a));

  stream_xor_cipher #(.W(8), .DEPTH(4), .DROP_N(0)) u_b (
    .clk(clk), .rst(rst), .start(start), .ks_init_done(ks_init_done),
    .bus(if_b.slave), .busy(busy_b),
`ifdef STREAM_XOR_CIPHER_STATS_EN
    .word_count(wc_b), .ks_dropped(kd_b),
`endif
    .state(st_b));

  stream_xor_cipher #(.W(8), .DEPTH(4), .DROP_N(2)) u_d (
    .clk(clk), .rst(rst), .start(start), .ks_init_done(ks_init_done),
    .bus(if_d.slave), .busy(busy_d),
`ifdef STREAM_XOR_CIPHER_STATS_EN
    .word_count(wc_d), .ks_dropped(kd_d),
`endif
    .state(st_d));

  assign if_a.out_ready = chain ? if_b.in_ready : a_out_ready;
  assign if_b.in_valid  = chain && if_a.out_valid;
  assign if_b.in_data   = if_a.out_data;
  assign if_b.out_ready = 1'b1;
  assign if_d.out_ready = 1'b1;

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // which: 0 = u_a, 1 = u_b, 2 = u_d
  task automatic push_ks(input int which, input logic [7:0] d);
    logic rdy;
    rdy = 1'b0;
    case (which)
      0:       begin if_a.ks_valid = 1'b1; if_a.ks_data = d; end
      1:       begin if_b.ks_valid = 1'b1; if_b.ks_data = d; end
      default: begin if_d.ks_valid = 1'b1; if_d.ks_data = d; end
    endcase
    for (int n = 0; n < 200 && !rdy; n++) begin
      @(negedge clk);
      case (which)
        0:       rdy = if_a.ks_ready;
        1:       rdy = if_b.ks_ready;
        default: rdy = if_d.ks_ready;
      endcase
    end
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL ks_wait dut=%0d: ks_ready=0 after 200 cycles, required 1", which);
    end
    @(posedge clk); #1;
    case (which)
      0:       if_a.ks_valid = 1'b0;
      1:       if_b.ks_valid = 1'b0;
      default: if_d.ks_valid = 1'b0;
    endcase
  endtask

  // which: 0 = u_a, otherwise u_d
  task automatic push_in(input int which, input logic [7:0] d);
    logic rdy;
    rdy = 1'b0;
    if (which == 0) begin if_a.in_valid = 1'b1; if_a.in_data = d; end
    else            begin if_d.in_valid = 1'b1; if_d.in_data = d; end
    for (int n = 0; n < 200 && !rdy; n++) begin
      @(negedge clk);
      rdy = (which == 0) ? if_a.in_ready : if_d.in_ready;
    end
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL in_wait dut=%0d: in_ready=0 after 200 cycles, required 1", which);
    end
    @(posedge clk); #1;
    if (which == 0) if_a.in_valid = 1'b0;
    else            if_d.in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (st_a !== IDLE)        begin errors++; $display("FAIL reset_state: got %0d, required %0d", st_a, IDLE); end
    checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0 || busy_d !== 1'b0)
      begin errors++; $display("FAIL reset_busy: got %b%b%b, required 000", busy_a, busy_b, busy_d); end
    checks++; if (st_b !== IDLE || st_d !== IDLE)
      begin errors++; $display("FAIL reset_state_bd: got %0d/%0d, required 0/0", st_b, st_d); end
    checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", if_a.out_valid); end
    checks++; if (if_a.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h, required 00", if_a.out_data); end
    checks++; if (if_a.ks_ready !== 1'b0)  begin errors++; $display("FAIL reset_ks_ready: got %b, required 0", if_a.ks_ready); end
    checks++; if (if_a.in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready: got %b, required 0", if_a.in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] ks_v[3];
    logic [7:0] in_v[3];
    logic [7:0] ex_v[3];
    ks_v = '{8'h3A, 8'h5C, 8'h11};
    in_v = '{8'h41, 8'h42, 8'h43};
    ex_v = '{8'h7B, 8'h1E, 8'h52};
    a_out_ready = 1'b1;
    pulse_start();
    checks++; if (st_a !== FLUSH) begin errors++; $display("FAIL basic_flush: got %0d, required %0d", st_a, FLUSH); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b, required 1", busy_a); end
    for (int i = 0; i < 3; i++) push_ks(0, ks_v[i]);
    for (int i = 0; i < 3; i++) begin
      push_in(0, in_v[i]);
      checks++;
      if (if_a.out_valid !== 1'b1 || if_a.out_data !== ex_v[i]) begin
        errors++; $display("FAIL basic_out%0d: got v=%b d=%h, required v=1 d=%h", i, if_a.out_valid, if_a.out_data, ex_v[i]);
      end
    end
    @(negedge clk);
    checks++; if (if_a.in_ready !== 1'b0) begin errors++; $display("FAIL basic_empty_in_ready: got %b, required 0", if_a.in_ready); end
    @(posedge clk); #1;
    checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b, required 0", if_a.out_valid); end
`ifdef STREAM_XOR_CIPHER_STATS_EN
    checks++; if (wc_a !== 32'd3) begin errors++; $display("FAIL basic_word_count: got %0d, required 3", wc_a); end
`endif
  endtask

  task automatic test_drop();
    pulse_start();
    push_ks(2, 8'h01);
    push_ks(2, 8'h02);
    checks++; if (st_d !== RUN) begin errors++; $display("FAIL drop_state: got %0d, required %0d", st_d, RUN); end
    checks++; if (if_d.in_ready !== 1'b0) begin errors++; $display("FAIL drop_not_stored: in_ready got %b, required 0", if_d.in_ready); end
`ifdef STREAM_XOR_CIPHER_STATS_EN
    checks++; if (kd_d !== 8'd2) begin errors++; $display("FAIL drop_count: got %0d, required 2", kd_d); end
`endif
    push_ks(2, 8'hF0);
    push_in(2, 8'h0F);
    checks++;
    if (if_d.out_valid !== 1'b1 || if_d.out_data !== 8'hFF) begin
      errors++; $display("FAIL drop_out: got v=%b d=%h, required v=1 d=ff", if_d.out_valid, if_d.out_data);
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b1;
    pulse_start();
    push_ks(0, 8'h10); push_ks(0, 8'h20); push_ks(0, 8'h30); push_ks(0, 8'h40);
    if_a.ks_valid = 1'b1; if_a.ks_data = 8'h99;
    repeat (2) begin
      @(negedge clk);
      checks++; if (if_a.ks_ready !== 1'b0) begin errors++; $display("FAIL bp_full: ks_ready got %b, required 0", if_a.ks_ready); end
    end
    @(posedge clk); #1;
    if_a.ks_valid = 1'b0;
    a_out_ready = 1'b0;
    push_in(0, 8'h01);
    checks++; if (if_a.out_data !== 8'h11) begin errors++; $display("FAIL bp_first: got %h, required 11", if_a.out_data); end
    if_a.in_valid = 1'b1; if_a.in_data = 8'h02;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (if_a.in_ready !== 1'b0 || if_a.out_valid !== 1'b1 || if_a.out_data !== 8'h11) begin
        errors++; $display("FAIL bp_hold%0d: got rdy=%b v=%b d=%h, required rdy=0 v=1 d=11", c, if_a.in_ready, if_a.out_valid, if_a.out_data);
      end
    end
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    if_a.in_valid = 1'b0;
    checks++; if (if_a.out_valid !== 1'b1 || if_a.out_data !== 8'h22)
      begin errors++; $display("FAIL bp_refill: got v=%b d=%h, required v=1 d=22", if_a.out_valid, if_a.out_data); end
    push_in(0, 8'h03);
    checks++; if (if_a.out_data !== 8'h33) begin errors++; $display("FAIL bp_w2: got %h, required 33", if_a.out_data); end
    push_in(0, 8'h04);
    checks++; if (if_a.out_data !== 8'h44) begin errors++; $display("FAIL bp_w3: got %h, required 44", if_a.out_data); end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_restart();
    a_out_ready = 1'b1;
    pulse_start();
    push_ks(0, 8'hA1); push_ks(0, 8'hB2); push_ks(0, 8'hC3); push_ks(0, 8'hD4);
    a_out_ready = 1'b0;
    push_in(0, 8'h01);
    ks_init_done = 1'b0;
    pulse_start();
    checks++; if (st_a !== FLUSH) begin errors++; $display("FAIL rs_flush: got %0d, required %0d", st_a, FLUSH); end
    checks++; if (if_a.out_valid !== 1'b1 || if_a.out_data !== 8'hA0)
      begin errors++; $display("FAIL rs_pending: got v=%b d=%h, required v=1 d=a0", if_a.out_valid, if_a.out_data); end
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (st_a !== WAIT) begin errors++; $display("FAIL rs_wait: got %0d, required %0d", st_a, WAIT); end
    checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL rs_consumed: got %b, required 0", if_a.out_valid); end
    @(posedge clk); #1;
    checks++; if (st_a !== WAIT || if_a.ks_ready !== 1'b0 || if_a.in_ready !== 1'b0)
      begin errors++; $display("FAIL rs_hold: got st=%0d ks_rdy=%b in_rdy=%b, required st=%0d 0 0", st_a, if_a.ks_ready, if_a.in_ready, WAIT); end
    ks_init_done = 1'b1;
    push_ks(0, 8'h5A);
    push_in(0, 8'h0F);
    checks++; if (if_a.out_data !== 8'h55) begin errors++; $display("FAIL rs_first_ks: got %h, required 55", if_a.out_data); end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_enc_dec();
    for (int i = 0; i < 64; i++) begin
      ks_arr[i] = 8'($urandom_range(0, 255));
      pt_arr[i] = 8'($urandom_range(0, 255));
      exp_q.push_back(pt_arr[i]);
    end
    chain = 1'b1;
    pulse_start();
    fork
      begin for (int i = 0; i < 64; i++) push_ks(0, ks_arr[i]); end
      begin for (int j = 0; j < 64; j++) push_ks(1, ks_arr[j]); end
      begin for (int k = 0; k < 64; k++) push_in(0, pt_arr[k]); end
      begin
        for (int m = 0; m < 64; m++) begin
          logic seen;
          logic [7:0] exp_v;
          seen = 1'b0;
          for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            seen = if_b.out_valid;
          end
          exp_v = exp_q.pop_front();
          checks++;
          if (!seen || if_b.out_data !== exp_v) begin
            errors++; $display("FAIL encdec_w%0d: got v=%b d=%h, required v=1 d=%h", m, seen, if_b.out_data, exp_v);
          end
        end
      end
    join
    repeat (2) @(posedge clk); #1;
    chain = 1'b0;
  endtask

  task automatic test_rst_mid();
    a_out_ready = 1'b1;
    pulse_start();
    push_ks(0, 8'h77);
    a_out_ready = 1'b0;
    push_in(0, 8'h11);
    checks++; if (if_a.out_valid !== 1'b1 || if_a.out_data !== 8'h66)
      begin errors++; $display("FAIL rm_pending: got v=%b d=%h, required v=1 d=66", if_a.out_valid, if_a.out_data); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (if_a.out_valid !== 1'b0 || if_a.out_data !== 8'h00)
      begin errors++; $display("FAIL rm_out: got v=%b d=%h, required v=0 d=00", if_a.out_valid, if_a.out_data); end
    checks++; if (busy_a !== 1'b0 || st_a !== IDLE)
      begin errors++; $display("FAIL rm_state: got busy=%b st=%0d, required busy=0 st=%0d", busy_a, st_a, IDLE); end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; ks_init_done = 1'b1; chain = 1'b0; a_out_ready = 1'b1;
    if_a.ks_valid = 1'b0; if_a.ks_data = '0; if_a.in_valid = 1'b0; if_a.in_data = '0;
    if_b.ks_valid = 1'b0; if_b.ks_data = '0;
    if_d.ks_valid = 1'b0; if_d.ks_data = '0; if_d.in_valid = 1'b0; if_d.in_data = '0;
    test_reset();
    test_basic();
    test_drop();
    test_backpressure();
    test_restart();
    test_enc_dec();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
